i2c_disp_target: RTL and testbench
==================================

I2C_DISP_TARGET -- requirements
Module: i2c_disp_target

Interface
REQ-001 The module SHALL have exactly one clock and one reset: clk_i is the single clock; reset_ni is an asynchronous, active-low reset.
REQ-002 Parameter DEV_ADDR, default 7'h38: 7-bit I2C target address.
REQ-003 Parameter FILTER_LEN, default 4: number of consecutive stable clk_i samples a line needs before its filtered value changes.
REQ-004 Parameter ID_VALUE, default 8'hA5: read-only contents of register 3.
REQ-005 clk_i  input  1  system clock, 100 MHz.
REQ-006 reset_ni  input  1  asynchronous active-low reset.
REQ-007 scl_i  input  1  I2C clock from the bus (asynchronous to clk_i).
REQ-008 sda_i  input  1  I2C data, sampled from the bus (asynchronous to clk_i).
REQ-009 sda_oe_o  output  1  1 = pull SDA low; 0 = release SDA. The top level builds the open-drain pad.
REQ-010 data_o  output  16  committed display word, {reg1, reg0}.
REQ-011 enable_o  output  1  reg2 bit 0 (display enable).
REQ-012 data_valid_o  output  1  one-cycle pulse when data_o updates.
REQ-013 busy_o  output  1  high from an addressed START until the following STOP.

Function
REQ-014 scl_i and sda_i SHALL each pass through a 2-flop synchronizer, then a FILTER_LEN stability filter; all logic uses only the filtered values scl_f and sda_f.
REQ-015 START condition: sda_f falls while scl_f is high. STOP condition: sda_f rises while scl_f is high. Both are detected in any state, including mid-byte.
REQ-016 FSM states: IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_WDATA, RDATA, RACK, IGNORE.
REQ-017 A START (or repeated START) SHALL clear the bit counter and go to ADDR; a STOP SHALL go to IDLE and release sda_oe_o within 1 clk_i.
REQ-018 Bits are sampled on the scl_f rising edge, MSB first; 8 bits make a byte.
REQ-019 Address match, write: address equals DEV_ADDR with R/W=0. Drive ACK (sda_oe_o=1) from the next scl_f fall to the following scl_f fall, then go to PTR.
REQ-020 Address match, read: address equals DEV_ADDR with R/W=1. ACK, then go to RDATA.
REQ-021 Address mismatch: no ACK; go to IGNORE until the next START or STOP.
REQ-022 PTR byte: the pointer is loaded from byte[1:0]; upper bits are ignored; the byte is ACKed.
REQ-023 WDATA byte: written to reg[ptr] at the ACK phase, then ptr is incremented modulo 4 (wrap 3->0).
REQ-024 A write to reg3 SHALL be ACKed but discarded.
REQ-025 RDATA: drive reg[ptr] MSB first. Change SDA only after an scl_f fall; sda_oe_o = ~bit.
REQ-026 RDATA: release SDA during the master ACK bit; increment ptr modulo 4.
REQ-027 Master ACK -> next byte. Master NACK -> IGNORE (await STOP).
REQ-028 Commit on STOP: if reg0 or reg1 was written in the transaction, load data_o={reg1,reg0} in the cycle after STOP detection and pulse data_valid_o for exactly 1 cycle. Otherwise, no pulse.
REQ-029 Repeated START does not commit; the commit-pending flag persists until STOP.
REQ-030 A START or STOP mid-byte SHALL discard the partial byte; bytes already ACKed remain written.
REQ-031 enable_o SHALL follow reg2[0] immediately; it is not gated by STOP.
REQ-032 busy_o SHALL be set at address match and cleared on STOP.

Reset
REQ-033 On reset_ni low: state=IDLE; ptr=0; reg0=reg1=reg2=0; data_o=0; enable_o=0; data_valid_o=0; busy_o=0; sda_oe_o=0; synchronizer and filter outputs=1 (bus idle).
REQ-034 Reset asserted mid-transfer SHALL release SDA asynchronously; after release, the module ignores the bus until the next START.

Structure
REQ-035 A shared package i2c_pkg SHALL hold the FSM state enum, REG_DATA_LO=0, REG_DATA_HI=1, REG_CTRL=2, REG_ID=3, and the default address 7'h38.
REQ-036 One sub-module, i2c_line_filter (synchronizer plus stability filter, instantiated once per line), SHALL be used; the FSM and register file stay in the top-level module.

Verification
REQ-037 Write 0x70, 0x00, 0x34, 0x12, STOP -> all ACKed; data_o=16'h1234 and data_valid_o pulses once, 1 cycle after STOP.
REQ-038 Address 0x72 (wrong address), then data -> SDA never driven; data_o unchanged; busy_o stays 0.
REQ-039 Write ptr=3, then 0xFF, 0xAB, 0xCD -> reg3 unchanged (ACKed); wrap writes reg0=0xAB and reg1=0xCD; commit gives 16'hCDAB.
REQ-040 Write ptr=2, repeated START, read 0x71, read 3 bytes ACK/ACK/NACK -> returns reg2, 0xA5, reg0; STOP; no data_valid_o pulse.
REQ-041 STOP after 4 bits of the data byte for reg1 following an ACKed reg0=0x55 -> data_o={old reg1, 0x55}, one pulse.
REQ-042 A 2-cycle glitch on SCL and reset asserted mid-ACK -> glitch ignored (FILTER_LEN=4); sda_oe_o=0 immediately on reset; all outputs return to reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_pkg -- shared FSM states and register map for i2c_disp_target   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ACK_ADDR  = 4'd2,
    ST_PTR       = 4'd3,
    ST_ACK_PTR   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_ACK_WDATA = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8,
    ST_IGNORE    = 4'd9
  } state_e;

  localparam logic [1:0] REG_DATA_LO = 2'd0;
  localparam logic [1:0] REG_DATA_HI = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_ID      = 2'd3;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h38;

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_line_filter -- 2-flop synchronizer plus N-sample glitch filter  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic line_i,
  output logic line_o
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       sync_q;
  logic             filt_q;
  logic [CNT_W-1:0] cnt_q;

  // Output flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      if (sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_q <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign line_o = filt_q;

endmodule
`default_nettype wire

// File: rtl/i2c_disp_target.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_disp_target -- I2C target with 4-byte register file, display   |
// | word committed on STOP.                      Revision: 1.0         |
// +--------------------------------------------------------------------+
module i2c_disp_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = DEFAULT_DEV_ADDR,
  parameter int         FILTER_LEN = 4,
  parameter logic [7:0] ID_VALUE   = 8'hA5
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  output logic [15:0] data_o,
  output logic        enable_o,
  output logic        data_valid_o,
  output logic        busy_o
);

  logic scl_f, sda_f;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .line_i   (scl_i),
    .line_o   (scl_f)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .line_i   (sda_i),
    .line_o   (sda_f)
  );

  state_e      state_q;
  logic        scl_q, sda_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [1:0]  ptr_q;
  logic [7:0]  reg0_q, reg1_q, reg2_q;
  logic        mnack_q;
  logic        commit_pend_q;
  logic        sda_oe_q;
  logic [15:0] data_q;
  logic        dv_q;
  logic        busy_q;

  logic scl_rise, scl_fall, start_det, stop_det, byte_done;
  logic [7:0] rd_byte;

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  assign byte_done = scl_fall && (bit_cnt_q == 4'd8);

  always_comb begin
    rd_byte = ID_VALUE;
    case (ptr_q)
      REG_DATA_LO: rd_byte = reg0_q;
      REG_DATA_HI: rd_byte = reg1_q;
      REG_CTRL:    rd_byte = reg2_q;
      REG_ID:      rd_byte = ID_VALUE;
      default:     rd_byte = ID_VALUE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= ST_IDLE;
      scl_q         <= 1'b1;
      sda_q         <= 1'b1;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'h00;
      ptr_q         <= 2'd0;
      reg0_q        <= 8'h00;
      reg1_q        <= 8'h00;
      reg2_q        <= 8'h00;
      mnack_q       <= 1'b0;
      commit_pend_q <= 1'b0;
      sda_oe_q      <= 1'b0;
      data_q        <= 16'h0000;
      dv_q          <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
      dv_q  <= 1'b0;
      if (start_det) begin
        state_q   <= ST_ADDR;
        bit_cnt_q <= 4'd0;
        sda_oe_q  <= 1'b0;
      end else if (stop_det) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= 4'd0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        if (commit_pend_q) begin
          data_q        <= {reg1_q, reg0_q};
          dv_q          <= 1'b1;
          commit_pend_q <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise && (bit_cnt_q != 4'd8)) begin
              shift_q   <= {shift_q[6:0], sda_f};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (byte_done) begin
              bit_cnt_q <= 4'd0;
              if (state_q == ST_ADDR) begin
                if (shift_q[7:1] == DEV_ADDR) begin
                  state_q  <= ST_ACK_ADDR;
                  sda_oe_q <= 1'b1;
                  busy_q   <= 1'b1;
                end else begin
                  state_q <= ST_IGNORE;
                end
              end else if (state_q == ST_PTR) begin
                ptr_q    <= shift_q[1:0];
                state_q  <= ST_ACK_PTR;
                sda_oe_q <= 1'b1;
              end else begin
                // Register is updated as the ACK starts; REG_ID writes are dropped.
                if (ptr_q == REG_DATA_LO) reg0_q <= shift_q;
                if (ptr_q == REG_DATA_HI) reg1_q <= shift_q;
                if (ptr_q == REG_CTRL)    reg2_q <= shift_q;
                if ((ptr_q == REG_DATA_LO) || (ptr_q == REG_DATA_HI))
                  commit_pend_q <= 1'b1;
                ptr_q    <= ptr_q + 2'd1;
                state_q  <= ST_ACK_WDATA;
                sda_oe_q <= 1'b1;
              end
            end
          end
          ST_ACK_ADDR: begin
            if (scl_fall) begin
              if (shift_q[0]) begin
                state_q   <= ST_RDATA;
                shift_q   <= rd_byte;
                sda_oe_q  <= ~rd_byte[7];
                bit_cnt_q <= 4'd0;
              end else begin
                state_q  <= ST_PTR;
                sda_oe_q <= 1'b0;
              end
            end
          end
          ST_ACK_PTR, ST_ACK_WDATA: begin
            if (scl_fall) begin
              state_q  <= ST_WDATA;
              sda_oe_q <= 1'b0;
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q  <= 1'b0;
                ptr_q     <= ptr_q + 2'd1;
                bit_cnt_q <= 4'd0;
                state_q   <= ST_RACK;
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= ~shift_q[6];
              end
            end
          end
          ST_RACK: begin
            if (scl_rise) begin
              mnack_q <= sda_f;
            end else if (scl_fall) begin
              if (!mnack_q) begin
                state_q   <= ST_RDATA;
                shift_q   <= rd_byte;
                sda_oe_q  <= ~rd_byte[7];
                bit_cnt_q <= 4'd0;
              end else begin
                state_q <= ST_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe_o     = sda_oe_q;
  assign data_o       = data_q;
  assign enable_o     = reg2_q[0];
  assign data_valid_o = dv_q;
  assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_disp_target.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_i2c_disp_target -- bit-banged I2C master with scoreboard checks  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_i2c_disp_target;

  typedef enum logic [2:0] {OP_START, OP_WR, OP_RD, OP_STOP, OP_STOPMID} op_e;
  typedef struct {
    op_e         op;
    logic [7:0]  data;
    logic        flag;   // WR: expected ACK, RD: master NACK, STOP: expected commit
    logic [15:0] exp;    // RD: expected byte, STOP: expected data_o
    logic        busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe_o;
  logic [15:0] data_o;
  logic        enable_o;
  logic        data_valid_o;
  logic        busy_o;

  int n_chk = 0;
  int n_pass = 0;
  int dv_count = 0;
  int oe_cycles = 0;
  logic busy_seen = 1'b0;
  logic dv_prev = 1'b0;

  logic        ack_q[$];
  logic [7:0]  rd_q[$];
  logic [15:0] commit_q[$];
  vec_t        tbl[$];

  assign sda_bus = sda_m & ~sda_oe_o;

  always #5 clk = ~clk;

  i2c_disp_target #(
    .DEV_ADDR   (7'h38),
    .FILTER_LEN (4),
    .ID_VALUE   (8'hA5)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .scl_i        (scl_m),
    .sda_i        (sda_bus),
    .sda_oe_o     (sda_oe_o),
    .data_o       (data_o),
    .enable_o     (enable_o),
    .data_valid_o (data_valid_o),
    .busy_o       (busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (sda_oe_o) oe_cycles++;
    if (busy_o) busy_seen = 1'b1;
    if (data_valid_o) begin
      dv_count++;
      check("pulse_width", 32'(dv_prev), 32'(1'b0));
      check("commit_expected", 32'(commit_q.size() != 0), 32'(1'b1));
      if (commit_q.size() != 0) check("commit_data", 32'(data_o), 32'(commit_q.pop_front()));
    end
    dv_prev = data_valid_o;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clk_bit(input logic b, output logic s);
    wait_clk(10); sda_m = b;
    wait_clk(10); scl_m = 1'b1;
    wait_clk(10); s = sda_bus;
    wait_clk(10); scl_m = 1'b0;
  endtask

  task automatic do_start();
    wait_clk(10); sda_m = 1'b1;
    wait_clk(10); scl_m = 1'b1;
    wait_clk(20); sda_m = 1'b0;
    wait_clk(20); scl_m = 1'b0;
  endtask

  task automatic do_stop();
    wait_clk(10); sda_m = 1'b0;
    wait_clk(10); scl_m = 1'b1;
    wait_clk(20); sda_m = 1'b1;
    wait_clk(20);
  endtask

  function automatic vec_t V(op_e op, logic [7:0] d, logic f, logic [15:0] x, logic b);
    vec_t r;
    r.op = op; r.data = d; r.flag = f; r.exp = x; r.busy = b;
    return r;
  endfunction

  task automatic apply_vec(input vec_t v);
    logic s, ack;
    logic [7:0] rb;
    int dv0;
    case (v.op)
      OP_START: do_start();
      OP_WR: begin
        ack_q.push_back(v.flag);
        for (int i = 7; i >= 0; i--) clk_bit(v.data[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
        check($sformatf("ack_%02h", v.data), 32'(ack), 32'(ack_q.pop_front()));
      end
      OP_RD: begin
        rd_q.push_back(v.exp[7:0]);
        for (int i = 7; i >= 0; i--) begin
          clk_bit(1'b1, s);
          rb[i] = s;
        end
        check("rdata", 32'(rb), 32'(rd_q.pop_front()));
        clk_bit(v.flag, s);
      end
      default: begin
        if (v.op == OP_STOPMID)
          for (int i = 7; i >= 4; i--) clk_bit(v.data[i], s);
        dv0 = dv_count;
        if (v.flag) commit_q.push_back(v.exp);
        do_stop();
        wait_clk(20);
        check("pulse_count", 32'(dv_count - dv0), 32'(v.flag));
        check("data_o", 32'(data_o), 32'(v.exp));
        check("sda_released", 32'(sda_oe_o), 32'(1'b0));
      end
    endcase
    check("busy", 32'(busy_o), 32'(v.busy));
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply_vec(tbl[i]);
  endtask

  initial begin
    int oe0, dv0;
    logic s;
    logic [7:0] ab;

    // 0-5: plain write 0x1234
    tbl.push_back(V(OP_START, 8'h00, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(V(OP_WR,    8'h70, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_WR,    8'h00, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_WR,    8'h34, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_WR,    8'h12, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_STOP,  8'h00, 1'b1, 16'h1234, 1'b0));
    // 6-12: ptr=3, ID write dropped, wrap to reg0/reg1
    tbl.push_back(V(OP_START, 8'h00, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(V(OP_WR,    8'h70, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_WR,    8'h03, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_WR,    8'hFF, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_WR,    8'hAB, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_WR,    8'hCD, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_STOP,  8'h00, 1'b1, 16'hCDAB, 1'b0));
    // 13-17: ctrl write only, no commit
    tbl.push_back(V(OP_START, 8'h00, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(V(OP_WR,    8'h70, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_WR,    8'h02, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_WR,    8'h01, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_STOP,  8'h00, 1'b0, 16'hCDAB, 1'b0));
    // 18-26: ptr=2, repeated START, read 3 bytes
    tbl.push_back(V(OP_START, 8'h00, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(V(OP_WR,    8'h70, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_WR,    8'h02, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_START, 8'h00, 1'b0, 16'h0000, 1'b1));
    tbl.push_back(V(OP_WR,    8'h71, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_RD,    8'h00, 1'b0, 16'h0001, 1'b1));
    tbl.push_back(V(OP_RD,    8'h00, 1'b0, 16'h00A5, 1'b1));
    tbl.push_back(V(OP_RD,    8'h00, 1'b1, 16'h00AB, 1'b1));
    tbl.push_back(V(OP_STOP,  8'h00, 1'b0, 16'hCDAB, 1'b0));
    // 27-30: wrong address
    tbl.push_back(V(OP_START, 8'h00, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(V(OP_WR,    8'h72, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(V(OP_WR,    8'h55, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(V(OP_STOP,  8'h00, 1'b0, 16'hCDAB, 1'b0));
    // 31-35: reg0=0x55 ACKed, STOP mid-byte of reg1
    tbl.push_back(V(OP_START, 8'h00, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(V(OP_WR,    8'h70, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_WR,    8'h00, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_WR,    8'h55, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_STOPMID, 8'h90, 1'b1, 16'hCD55, 1'b0));
    // 36-40: after reset, registers start from zero
    tbl.push_back(V(OP_START, 8'h00, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(V(OP_WR,    8'h70, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_WR,    8'h01, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_WR,    8'h77, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(V(OP_STOP,  8'h00, 1'b1, 16'h7700, 1'b0));

    wait_clk(5);
    check("rst_data_o", 32'(data_o), 32'(16'h0000));
    check("rst_sda_oe", 32'(sda_oe_o), 32'(1'b0));
    check("rst_busy", 32'(busy_o), 32'(1'b0));
    check("rst_enable", 32'(enable_o), 32'(1'b0));
    check("rst_dv", 32'(data_valid_o), 32'(1'b0));
    reset_ni = 1'b1;
    wait_clk(10);

    run(0, 17);
    check("enable_after_ctrl", 32'(enable_o), 32'(1'b1));
    run(18, 26);

    oe0 = oe_cycles;
    busy_seen = 1'b0;
    run(27, 30);
    check("wrong_addr_no_drive", 32'(oe_cycles - oe0), 32'(0));
    check("wrong_addr_no_busy", 32'(busy_seen), 32'(1'b0));

    run(31, 35);

    // Glitch during address ACK, then asynchronous reset while still in ACK.
    ab = 8'h70;
    do_start();
    for (int i = 7; i >= 0; i--) clk_bit(ab[i], s);
    wait_clk(12);
    check("ack_driven", 32'(sda_oe_o), 32'(1'b1));
    scl_m = 1'b1;
    wait_clk(2);
    scl_m = 1'b0;
    wait_clk(12);
    check("glitch_ignored", 32'(sda_oe_o), 32'(1'b1));
    #2 reset_ni = 1'b0;
    #1;
    check("async_sda_release", 32'(sda_oe_o), 32'(1'b0));
    check("reset_data_o", 32'(data_o), 32'(16'h0000));
    check("reset_enable", 32'(enable_o), 32'(1'b0));
    check("reset_busy", 32'(busy_o), 32'(1'b0));
    check("reset_dv", 32'(data_valid_o), 32'(1'b0));
    wait_clk(5);
    reset_ni = 1'b1;
    wait_clk(5);
    dv0 = dv_count;
    oe0 = oe_cycles;
    do_stop();
    wait_clk(20);
    check("post_reset_no_pulse", 32'(dv_count - dv0), 32'(0));
    check("post_reset_no_drive", 32'(oe_cycles - oe0), 32'(0));

    run(36, 40);

    check("commit_queue_drained", 32'(commit_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
